// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding, frame field positions and decoded frame type for the thermocouple poller
package tc_pkg;
  typedef enum logic [2:0] {
    ST_STARTUP, ST_SWEEP_START, ST_SELECT, ST_START, ST_WAIT_DONE, ST_CAPTURE, ST_NEXT, ST_GAP
  } state_t;
  localparam int TC_MSB = 31;
  localparam int TC_LSB = 18;
  localparam int JT_MSB = 15;
  localparam int JT_LSB = 4;
  localparam int OC_BIT = 16;
  localparam int FLT_MSB = 2;
  typedef struct packed {
    logic [13:0] tc_temp;
    logic [11:0] junc_temp;
    logic [3:0]  fault;
  } tc_frame_t;
endpackage

// File: rtl/tc_frame_regs.sv
// tc_frame_regs: per-channel decoded frame registers, valid/timeout flags and a registered read port (rd_ch -> rd_*)
module tc_frame_regs
  import tc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               to_set,
  input  logic [CH_BITS-1:0] wr_ch,
  input  tc_frame_t          wr_frame,
  input  logic [CH_BITS-1:0] rd_ch,
  output logic [13:0]        rd_tc_temp,
  output logic [11:0]        rd_junc_temp,
  output logic [3:0]         rd_fault,
  output logic               rd_valid,
  output logic               rd_timeout
);
  tc_frame_t regs [NUM_CH];
  logic [NUM_CH-1:0] valid, tmo;
  tc_frame_t rd_frame;
  logic rd_v, rd_t;
  always_comb begin
    rd_frame = '0;
    rd_v = 1'b0;
    rd_t = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_BITS'(i)) begin
        rd_frame = regs[i];
        rd_v = valid[i];
        rd_t = tmo[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
      valid <= '0;
      tmo <= '0;
      rd_tc_temp <= '0;
      rd_junc_temp <= '0;
      rd_fault <= '0;
      rd_valid <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ch == CH_BITS'(i) && wr_en) begin
          regs[i] <= wr_frame;
          valid[i] <= 1'b1;
          tmo[i] <= 1'b0;
        end else if (wr_ch == CH_BITS'(i) && to_set) begin
          tmo[i] <= 1'b1;
        end
      end
      rd_tc_temp <= rd_frame.tc_temp;
      rd_junc_temp <= rd_frame.junc_temp;
      rd_fault <= rd_frame.fault;
      rd_valid <= rd_v;
      rd_timeout <= rd_t;
    end
  end
endmodule

// File: rtl/tc_spi_scheduler.sv
// tc_spi_scheduler: round-robin SPI poller for NUM_CH thermocouple converters with decoded per-channel read port
module tc_spi_scheduler
  import tc_pkg::*;
#(
  parameter int CLK_FREQ     = 24000,
  parameter int NUM_CH       = 4,
  parameter int CH_BITS      = 2,
  parameter int CBITS        = 17,
  parameter int STARTUP_CYC  = CLK_FREQ * 3,
  parameter int GAP_CYC      = CLK_FREQ,
  parameter int CS_SETUP_CYC = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               spi_not_busy,
  input  logic [31:0]        spi_rx_data,
  output logic               spi_ena,
  output logic [NUM_CH-1:0]  spi_cs_n,
  input  logic [CH_BITS-1:0] rd_ch,
  output logic [13:0]        rd_tc_temp,
  output logic [11:0]        rd_junc_temp,
  output logic [3:0]         rd_fault,
  output logic               rd_valid,
  output logic               rd_timeout,
  output logic               sweep_done
);
  localparam int WBITS = $clog2(BUSY_TIMEOUT) + 1;
  state_t state, nxt;
  logic [CBITS-1:0] timer;
  logic [WBITS-1:0] wd;
  logic [CH_BITS-1:0] ch, nxt_ch, first_ch, next_ch;
  logic [NUM_CH-1:0] sweep_mask;
  logic first_hit, next_hit, busy_st, to_hit, unused_bits;
  tc_frame_t frame;
  assign frame = {spi_rx_data[TC_MSB:TC_LSB], spi_rx_data[JT_MSB:JT_LSB],
                  spi_rx_data[OC_BIT], spi_rx_data[FLT_MSB:0]};
  assign unused_bits = ^{spi_rx_data[17], spi_rx_data[3]};
  assign busy_st = state == ST_START || state == ST_WAIT_DONE;
  assign to_hit = busy_st && wd == WBITS'(BUSY_TIMEOUT - 1);
  always_comb begin
    first_hit = 1'b0;
    first_ch = '0;
    next_hit = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_hit = 1'b1;
        first_ch = CH_BITS'(i);
      end
      if (sweep_mask[i] && CH_BITS'(i) > ch) begin
        next_hit = 1'b1;
        next_ch = CH_BITS'(i);
      end
    end
  end
  always_comb begin
    nxt = state;
    nxt_ch = ch;
    case (state)
      ST_STARTUP:     nxt = timer == CBITS'(STARTUP_CYC - 1) ? ST_SWEEP_START : ST_STARTUP;
      ST_SWEEP_START: begin
        nxt = first_hit ? ST_SELECT : ST_GAP;
        nxt_ch = first_hit ? first_ch : ch;
      end
      ST_SELECT:      nxt = timer == CBITS'(CS_SETUP_CYC - 1) ? ST_START : ST_SELECT;
      ST_START:       nxt = to_hit ? ST_NEXT : !spi_not_busy ? ST_WAIT_DONE : ST_START;
      ST_WAIT_DONE:   nxt = spi_not_busy ? ST_CAPTURE : to_hit ? ST_NEXT : ST_WAIT_DONE;
      ST_CAPTURE:     nxt = ST_NEXT;
      ST_NEXT: begin
        nxt = next_hit ? ST_SELECT : ST_GAP;
        nxt_ch = next_hit ? next_ch : ch;
      end
      ST_GAP:         nxt = timer == CBITS'(GAP_CYC - 1) ? ST_SWEEP_START : ST_GAP;
      default:        nxt = ST_STARTUP;
    endcase
  end
  // bus outputs are registered from the next state so they switch cleanly with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STARTUP;
      timer <= '0;
      wd <= '0;
      ch <= '0;
      sweep_mask <= '0;
      spi_ena <= 1'b0;
      spi_cs_n <= '1;
      sweep_done <= 1'b0;
    end else begin
      state <= nxt;
      timer <= nxt != state ? '0 : timer + 1'b1;
      wd <= busy_st ? wd + 1'b1 : '0;
      ch <= nxt_ch;
      sweep_mask <= state == ST_SWEEP_START ? ch_mask : sweep_mask;
      spi_ena <= nxt == ST_START;
      spi_cs_n <= (nxt == ST_SELECT || nxt == ST_START || nxt == ST_WAIT_DONE) ?
                  ~(NUM_CH'(1) << nxt_ch) : '1;
      sweep_done <= state == ST_NEXT && !next_hit;
    end
  end
  tc_frame_regs #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_regs (
    .clk(clk),
    .rst(rst),
    .wr_en(state == ST_CAPTURE),
    .to_set(busy_st && nxt == ST_NEXT),
    .wr_ch(ch),
    .wr_frame(frame),
    .rd_ch(rd_ch),
    .rd_tc_temp(rd_tc_temp),
    .rd_junc_temp(rd_junc_temp),
    .rd_fault(rd_fault),
    .rd_valid(rd_valid),
    .rd_timeout(rd_timeout)
  );
endmodule
